// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmitter, 8N1 framing: LSB first, idle-high line, BIT_TICKS clk
//   cycles per bit. One holding register lets the controller queue the next
//   byte while the current frame is on the wire. Back-to-back frames have no
//   idle gap.
//
//   Optional build macro UART_TX_PARITY_EN inserts a parity bit between the
//   last data bit and the stop bit(s). PARITY_ODD selects odd parity.
//
// Ports
//   clk        16x baud clock, rising edge
//   reset      synchronous, active-high
//   tx_data    byte to send, sampled only when a write is accepted
//   tx_en      write strobe, accepted when tx_en=1 and tx_status=1
//   uart_tx    serial line, driven straight from a flop, idles at 1
//   tx_status  holding register empty (ready for a write)
//   tx_busy    a frame is in progress
//
// state  | meaning
// IDLE   | line high, waiting for a held byte
// START  | start bit (0) for BIT_TICKS cycles
// DATA   | 8 data bits, LSB first, BIT_TICKS cycles each
// PARITY | parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit(s) (1) for STOP_BITS*BIT_TICKS cycles
module uart_tx_serializer #(
  parameter int BIT_TICKS = 16,
  parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       uart_tx,
  output logic       tx_status,
  output logic       tx_busy
);

  localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_valid_q, hold_valid_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic          tx_q, tx_d;
  logic          status_q, status_d;
  logic          load;
  logic          tick_done;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign tick_done = (tick_q == TICK_LAST);

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    tick_d       = tick_q + TW'(1);
    bit_d        = bit_q;
    tx_d         = tx_q;
    load         = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    // Accept only into an empty holding register; writes while full are dropped.
    if (tx_en && !hold_valid_q) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        tick_d = '0;
        load   = hold_valid_q;
      end
      START: begin
        if (tick_done) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick_done) begin
          tick_d = '0;
          if (bit_q != 3'd7) begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end else begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_done) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        // bit_q counts stop bits here so 2-stop-bit frames reuse the same tick counter.
        if (tick_done) begin
          tick_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (hold_valid_q) load = 1'b1;
            else              state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // Transfer hold -> shift; never coincides with an accept (hold is full here).
    if (load) begin
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      tick_d       = '0;
      bit_d        = '0;
      state_d      = START;
      tx_d         = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d     = (^hold_q) ^ (PARITY_ODD != 0);
`endif
    end

    status_d = ~hold_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      tick_q       <= '0;
      bit_q        <= '0;
      tx_q         <= 1'b1;
      status_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      tx_q         <= tx_d;
      status_q     <= status_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign uart_tx   = tx_q;
  assign tx_status = status_q;
  assign tx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int BT = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR  = 1;
  localparam int PODD = 0;
`else
  localparam int PAR  = 0;
`endif
  localparam int NSLOT = 10 + PAR;
  localparam int FRAME = NSLOT * BT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_en = 1'b0;
  logic       uart_tx;
  logic       tx_status;
  logic       tx_busy;

  int n_chk = 0;
  int n_pass = 0;

  uart_tx_serializer #(
    .BIT_TICKS(BT),
    .STOP_BITS(1)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD(PODD)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .uart_tx  (uart_tx),
    .tx_status(tx_status),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for cycle k of a frame carrying byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    int slot;
    slot = k / BT;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return (^d) ^ (PODD != 0);
`endif
    return 1'b1;
  endfunction

  // Called just after the edge where the byte moved into the shifter.
  task automatic expect_frame(input logic [7:0] d, input string tag);
    int errs;
    errs = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (uart_tx !== exp_bit(d, k) || tx_busy !== 1'b1) errs++;
      if (k % BT == BT / 2)
        chk($sformatf("%s_slot%0d", tag, k / BT), {31'd0, uart_tx}, {31'd0, exp_bit(d, k)});
      step();
    end
    chk({tag, "_cycle_errs"}, errs, 0);
  endtask

  task automatic write_byte(input logic [7:0] d);
    tx_data = d;
    tx_en   = 1'b1;
    step();
    tx_en   = 1'b0;
  endtask

  task automatic loop_rx(input logic [7:0] d);
    logic [7:0] got;
    int         n;
    write_byte(d);
    n = 0;
    while (uart_tx !== 1'b0 && n < 10) begin step(); n++; end
    chk("rx_start_seen", {31'd0, n < 10}, 32'd1);
    repeat (BT / 2) step();
    chk("rx_start_mid", {31'd0, uart_tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (BT) step();
      got[i] = uart_tx;
    end
    repeat (BT * (1 + PAR)) step();
    chk("rx_stop", {31'd0, uart_tx}, 32'd1);
    chk($sformatf("rx_data_%02h", d), {24'd0, got}, {24'd0, d});
    n = 0;
    while (tx_busy !== 1'b0 && n < 40) begin step(); n++; end
    chk("rx_frame_end", {31'd0, tx_busy}, 32'd0);
  endtask

  initial begin
    int errs;

    // Reset and idle
    step(); step();
    reset = 1'b0;
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_status", {31'd0, tx_status}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (uart_tx !== 1'b1 || tx_status !== 1'b1 || tx_busy !== 1'b0) errs++;
    end
    chk("idle_errs", errs, 0);

    // Single frame 0x55
    write_byte(8'h55);
    chk("acc_status", {31'd0, tx_status}, 32'd0);
    chk("acc_tx_still_high", {31'd0, uart_tx}, 32'd1);
    chk("acc_busy", {31'd0, tx_busy}, 32'd0);
    step();
    chk("xfer_status", {31'd0, tx_status}, 32'd1);
    expect_frame(8'h55, "f55");
    chk("f55_end_busy", {31'd0, tx_busy}, 32'd0);
    chk("f55_end_tx", {31'd0, uart_tx}, 32'd1);
    repeat (5) step();

    // Back-to-back 0xA3 then 0x0F, with an ignored write of 0xEE
    write_byte(8'hA3);
    step();
    fork
      expect_frame(8'hA3, "fA3");
      begin
        tx_data = 8'h0F;
        tx_en   = 1'b1;
        step();
        chk("q2_status", {31'd0, tx_status}, 32'd0);
        tx_data = 8'hEE;
        repeat (20) step();
        tx_en = 1'b0;
      end
    join
    expect_frame(8'h0F, "f0F");
    chk("b2b_end_busy", {31'd0, tx_busy}, 32'd0);
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) errs++;
      step();
    end
    chk("no_third_frame", errs, 0);

    // Reset during data bit 4 of 0xFF with 0x12 queued
    write_byte(8'hFF);
    step();
    write_byte(8'h12);
    chk("rst_q_status", {31'd0, tx_status}, 32'd0);
    repeat (BT + 4 * BT + BT / 2 - 2) step();
    chk("rst_pre_busy", {31'd0, tx_busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_tx", {31'd0, uart_tx}, 32'd1);
    chk("midrst_status", {31'd0, tx_status}, 32'd1);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) errs++;
    end
    chk("midrst_no_frame", errs, 0);

    // Loopback decode
    loop_rx(8'h00);
    loop_rx(8'hFF);
    loop_rx(8'h5A);
    loop_rx(8'h81);

`ifdef UART_TX_PARITY_EN
    write_byte(8'h07);
    step();
    expect_frame(8'h07, "par07");
    chk("par07_end_busy", {31'd0, tx_busy}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
